// File: rtl/xor_rate_stage.sv
// Registered rate-injection stage ahead of the Ascon permutation: absorbs AD/PT/CT with 10* padding,
// injects the key, and emits masked output bytes. Optional domain separation via XOR_RATE_DOMSEP_EN.
module xor_rate_stage #(
    parameter int unsigned RATE_W = 128,
    parameter int unsigned KEY_W  = 128,
    localparam int unsigned LEN_W = $clog2(RATE_W/8 + 1)
) (
    input  logic                  clock_i,
    input  logic                  resetb_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            mode_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [4:0][63:0]      state_i,
    input  logic [KEY_W-1:0]      key_i,
    input  logic [RATE_W-1:0]     data_i,
`ifdef XOR_RATE_DOMSEP_EN
    input  logic                  dsep_i,
`endif
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4:0][63:0]      state_o,
    output logic [RATE_W-1:0]     data_o,
    output logic [LEN_W-1:0]      data_len_o
);

    localparam int unsigned NB = RATE_W / 8;
    localparam int unsigned NW = RATE_W / 64;

    typedef enum logic [2:0] {
        M_PASS      = 3'b000,
        M_AD        = 3'b001,
        M_ENC       = 3'b010,
        M_DEC       = 3'b011,
        M_FINAL_ENC = 3'b100,
        M_FINAL_DEC = 3'b101,
        M_KEY_TAIL  = 3'b110,
        M_RSVD      = 3'b111
    } mode_t;

    mode_t             mode;
    logic [LEN_W-1:0]  len_c;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] rate_nxt;
    logic [RATE_W-1:0] mask;
    logic [RATE_W-1:0] pad;
    logic [RATE_W-1:0] data_nxt;
    logic [4:0][63:0]  state_nxt;
    logic              accept;

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        mode     = mode_t'(mode_i);
        len_c    = (len_i > LEN_W'(NB)) ? LEN_W'(NB) : len_i;
        rate     = '0;
        mask     = '0;
        pad      = '0;
        for (int unsigned j = 0; j < NW; j++) begin
            rate[64*j +: 64] = state_i[j];
        end
        // Byte 0 is the MSB of word 0; pad lands on byte L only when L < NB.
        for (int unsigned k = 0; k < NB; k++) begin
            if (LEN_W'(k) < len_c)
                mask[64*(k/8) + 56 - 8*(k%8) +: 8] = '1;
            if (LEN_W'(k) == len_c)
                pad[64*(k/8) + 56 - 8*(k%8) +: 8] = 8'h80;
        end

        rate_nxt = rate;
        data_nxt = '0;
        case (mode)
            M_AD: begin
                rate_nxt = rate ^ (data_i & mask) ^ pad;
            end
            M_ENC, M_FINAL_ENC: begin
                rate_nxt = rate ^ (data_i & mask) ^ pad;
                data_nxt = rate_nxt & mask;
            end
            M_DEC, M_FINAL_DEC: begin
                data_nxt = (rate ^ data_i) & mask;
                rate_nxt = ((data_i & mask) | (rate & ~mask)) ^ pad;
            end
            default: ;
        endcase

        state_nxt = state_i;
        for (int unsigned j = 0; j < NW; j++) begin
            state_nxt[j] = rate_nxt[64*j +: 64];
        end
        if (mode == M_FINAL_ENC || mode == M_FINAL_DEC) begin
            state_nxt[NW]   = state_nxt[NW]   ^ key_i[63:0];
            state_nxt[NW+1] = state_nxt[NW+1] ^ key_i[127:64];
        end
        if (mode == M_KEY_TAIL) begin
            state_nxt[3] = state_nxt[3] ^ key_i[63:0];
            state_nxt[4] = state_nxt[4] ^ key_i[127:64];
        end
`ifdef XOR_RATE_DOMSEP_EN
        state_nxt[4][0] = state_nxt[4][0] ^ dsep_i;
`endif
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            out_valid_o <= 1'b0;
            state_o     <= '0;
            data_o      <= '0;
            data_len_o  <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            state_o     <= state_nxt;
            data_o      <= data_nxt;
            data_len_o  <= len_c;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_rate_stage.sv
// Scoreboard bench for xor_rate_stage: 128-bit and 64-bit rate instances share stimulus,
// checked against a byte-level reference model.
module tb_xor_rate_stage;

    typedef logic [4:0][63:0] st_t;
    typedef struct {
        st_t          st;
        logic [127:0] d;
        int unsigned  len;
    } exp_t;

`ifdef XOR_RATE_DOMSEP_EN
    localparam bit DSEP = 1'b1;
`else
    localparam bit DSEP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn, flush, in_valid, out_ready, dsep;
    logic [2:0]   mode;
    logic [4:0]   len_a;
    logic [3:0]   len_b;
    st_t          st_in;
    logic [127:0] key, data;

    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    st_t          st_a, st_b;
    logic [127:0] d_a;
    logic [63:0]  d_b;
    logic [4:0]   l_a;
    logic [3:0]   l_b;

    int   checks = 0, errors = 0;
    exp_t qa[$], qb[$];
    bit   exp_valid = 0, exp_valid_nxt = 0, drop = 0;

    always #5 clk = ~clk;

    xor_rate_stage #(.RATE_W(128), .KEY_W(128)) dut_a (
        .clock_i(clk), .resetb_i(rstn), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_a), .mode_i(mode), .len_i(len_a), .state_i(st_in),
        .key_i(key), .data_i(data),
`ifdef XOR_RATE_DOMSEP_EN
        .dsep_i(dsep),
`endif
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .state_o(st_a),
        .data_o(d_a), .data_len_o(l_a)
    );

    xor_rate_stage #(.RATE_W(64), .KEY_W(128)) dut_b (
        .clock_i(clk), .resetb_i(rstn), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_b), .mode_i(mode), .len_i(len_b), .state_i(st_in),
        .key_i(key), .data_i(data[63:0]),
`ifdef XOR_RATE_DOMSEP_EN
        .dsep_i(dsep),
`endif
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .state_o(st_b),
        .data_o(d_b), .data_len_o(l_b)
    );

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: treat the rate as an array of bytes, byte 0 = MSB of word 0.
    function automatic exp_t model(input int unsigned rw, input logic [2:0] m, input int unsigned len,
                                   input st_t s, input logic [127:0] k, input logic [127:0] d, input bit ds);
        int unsigned nb = rw / 8;
        int unsigned l;
        logic [7:0]  rb[16], db[16], ob[16];
        exp_t        e;
        l = (len > nb) ? nb : len;
        for (int unsigned i = 0; i < 16; i++) begin
            rb[i] = s[i/8][63 - 8*(i%8) -: 8];
            db[i] = d[64*(i/8) + 63 - 8*(i%8) -: 8];
            ob[i] = 8'h00;
        end
        case (m)
            3'd1, 3'd2, 3'd4: begin
                for (int unsigned i = 0; i < l; i++) rb[i] = rb[i] ^ db[i];
                if (l < nb) rb[l] = rb[l] ^ 8'h80;
                if (m != 3'd1)
                    for (int unsigned i = 0; i < l; i++) ob[i] = rb[i];
            end
            3'd3, 3'd5: begin
                for (int unsigned i = 0; i < l; i++) begin
                    ob[i] = rb[i] ^ db[i];
                    rb[i] = db[i];
                end
                if (l < nb) rb[l] = rb[l] ^ 8'h80;
            end
            default: ;
        endcase
        e.st = s;
        for (int unsigned i = 0; i < nb; i++) e.st[i/8][63 - 8*(i%8) -: 8] = rb[i];
        e.d = '0;
        for (int unsigned i = 0; i < l; i++) e.d[64*(i/8) + 63 - 8*(i%8) -: 8] = ob[i];
        if (m == 3'd4 || m == 3'd5) begin
            e.st[rw/64]   = e.st[rw/64]   ^ k[63:0];
            e.st[rw/64+1] = e.st[rw/64+1] ^ k[127:64];
        end
        if (m == 3'd6) begin
            e.st[3] = e.st[3] ^ k[63:0];
            e.st[4] = e.st[4] ^ k[127:64];
        end
        if (DSEP && ds) e.st[4][0] = ~e.st[4][0];
        e.len = l;
        return e;
    endfunction

    function automatic st_t rand_st();
        st_t s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic step(input bit v, input logic [2:0] m, input int unsigned la, input int unsigned lb,
                        input st_t s, input logic [127:0] k, input logic [127:0] d,
                        input bit ds, input bit fl, input bit ordy);
        bit acc;
        @(posedge clk);
        #1;
        exp_valid = exp_valid_nxt;
        if (drop) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
            drop = 0;
        end
        in_valid = v; mode = m; len_a = la[4:0]; len_b = lb[3:0];
        st_in = s; key = k; data = d; dsep = ds; flush = fl; out_ready = ordy;
        #1;
        check("in_ready_a", 320'(in_ready_a), 320'(!exp_valid || ordy));
        check("in_ready_b", 320'(in_ready_b), 320'(!exp_valid || ordy));
        check("out_valid_a", 320'(out_valid_a), 320'(exp_valid));
        check("out_valid_b", 320'(out_valid_b), 320'(exp_valid));
        acc = v && !fl && (!exp_valid || ordy);
        if (acc) begin
            qa.push_back(model(128, m, la[4:0], s, k, d, ds));
            qb.push_back(model(64, m, lb[3:0], s, k, {64'h0, d[63:0]}, ds));
        end
        if (fl && exp_valid && !ordy) drop = 1;
        exp_valid_nxt = fl ? 1'b0 : acc ? 1'b1 : (ordy ? 1'b0 : exp_valid);
    endtask

    // Monitor: compare the head of each queue while valid; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (out_valid_a) begin
                    if (qa.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL a_unexpected_valid: got 1 expected 0");
                    end else begin
                        check("a_state", st_a, qa[0].st);
                        check("a_data", 320'(d_a), 320'(qa[0].d));
                        check("a_len", 320'(l_a), 320'(qa[0].len));
                        if (out_ready) void'(qa.pop_front());
                    end
                end
                if (out_valid_b) begin
                    if (qb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected_valid: got 1 expected 0");
                    end else begin
                        check("b_state", st_b, qb[0].st);
                        check("b_data", 320'(d_b), 320'(qb[0].d));
                        check("b_len", 320'(l_b), 320'(qb[0].len));
                        if (out_ready) void'(qb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        st_t          s;
        logic [127:0] kp;
        kp = {64'hA1A1A1A1A1A1A1A1, 64'hB0B0B0B0B0B0B0B0};
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; dsep = 1'b0;
        mode = 3'd1; len_a = 5'd16; len_b = 4'd8; st_in = rand_st(); key = '1; data = '1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid_a", 320'(out_valid_a), 320'(0));
        check("rst_valid_b", 320'(out_valid_b), 320'(0));
        check("rst_state_a", st_a, 320'(0));
        check("rst_data_a", 320'(d_a), 320'(0));
        check("rst_len_a", 320'(l_a), 320'(0));
        check("rst_ready_a", 320'(in_ready_a), 320'(1));
        check("rst_ready_b", 320'(in_ready_b), 320'(1));
        in_valid = 1'b0;
        rstn = 1'b1;

        // Directed vectors
        step(1, 3'd1, 16, 8, '0, '0, 128'h00112233445566778899AABBCCDDEEFF, 0, 0, 1);
        step(1, 3'd2, 3, 3, '0, '0, {64'h1111111111111111, 64'hAABBCCDDEEFF0011}, 0, 0, 1);
        s = '0; s[0] = 64'h0123456789ABCDEF;
        step(1, 3'd3, 0, 0, s, '0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
        step(1, 3'd4, 16, 8, '0, kp, '0, 0, 0, 1);
        step(1, 3'd5, 5, 5, rand_st(), kp, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
        step(1, 3'd6, 7, 7, '0, kp, '1, 0, 0, 1);
        step(1, 3'd7, 2, 2, rand_st(), kp, '1, 1, 0, 1);
        step(1, 3'd0, 2, 2, rand_st(), kp, '1, 0, 0, 1);
        // Backpressure: hold, then flush the pending result, then an over-long length
        step(1, 3'd2, 9, 4, rand_st(), kp, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
        step(1, 3'd3, 4, 2, rand_st(), kp, '1, 0, 0, 0);
        step(1, 3'd3, 4, 2, rand_st(), kp, '1, 0, 0, 0);
        step(1, 3'd1, 4, 2, rand_st(), kp, '1, 0, 1, 0);
        step(1, 3'd2, 20, 12, rand_st(), kp, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);
        step(1, 3'd5, 31, 15, rand_st(), kp, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 20), $urandom_range(0, 10), rand_st(),
                 {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end

        // Reset while a result is pending
        step(1, 3'd2, 6, 6, rand_st(), kp, '1, 0, 0, 0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_valid_a", 320'(out_valid_a), 320'(0));
        check("midrst_valid_b", 320'(out_valid_b), 320'(0));
        check("midrst_state_a", st_a, 320'(0));
        qa.delete(); qb.delete();
        exp_valid_nxt = 0; drop = 0; in_valid = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b1;

        step(1, 3'd4, 11, 3, rand_st(), kp, '1, 0, 0, 1);
        repeat (3) step(0, 3'd0, 0, 0, '0, '0, '0, 0, 0, 1);
        @(negedge clk);
        #1;
        check("drain_a", 320'(qa.size()), 320'(0));
        check("drain_b", 320'(qb.size()), 320'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
